// File: rtl/btb_update_queue.sv
// rtl/btb_update_queue.sv - taken-branch update FIFO feeding the BTB write port, with same-PC coalescing
// Optional counters under BTB_UPD_STATS_EN.
module btb_update_queue #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5,
    parameter int TAG_W = 10,
    parameter int PC_W  = 32
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [1:0]                rt_valid,
    input  logic [1:0]                rt_taken,
    input  logic [2*PC_W-1:0]         rt_pc,
    input  logic [2*PC_W-1:0]         rt_target,
    output logic                      rt_ready,
    output logic                      wr_en,
    output logic [IDX_W-1:0]          wr_idx,
    output logic [TAG_W-1:0]          wr_tag,
    output logic [PC_W-1:0]           wr_data,
    output logic [$clog2(DEPTH):0]    count
`ifdef BTB_UPD_STATS_EN
    ,
    output logic [31:0]               stat_writes,
    output logic [31:0]               stat_merges,
    output logic [31:0]               stat_full_cycles
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    head, tail, tail_plus;
    logic [DEPTH-1:0] ent_valid;
    logic [PC_W-1:0]  ent_pc  [DEPTH];
    logic [PC_W-1:0]  ent_tgt [DEPTH];

    logic [PC_W-1:0]  pc0, pc1, tgt0, tgt1;
    logic             pop, cand0, cand1, same_pc, eff0, eff1;
    logic [DEPTH-1:0] hit0, hit1;
    logic             alloc0, alloc1;

    assign pc0  = rt_pc[PC_W-1:0];
    assign pc1  = rt_pc[2*PC_W-1:PC_W];
    assign tgt0 = rt_target[PC_W-1:0];
    assign tgt1 = rt_target[2*PC_W-1:PC_W];

    assign rt_ready = (count <= CW'(DEPTH - 2));
    assign pop      = (count != '0);
    assign cand0    = rt_valid[0] & rt_taken[0] & rt_ready;
    assign cand1    = rt_valid[1] & rt_taken[1] & rt_ready;

    // Equal-PC lanes collapse onto lane 1 so one entry carries the younger target.
    assign same_pc  = cand0 & cand1 & (pc0 == pc1);
    assign eff0     = cand0 & ~same_pc;
    assign eff1     = cand1;

    // The head leaving this cycle is not a merge target; a match there allocates anew.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            hit0[i] = ent_valid[i] && (ent_pc[i] == pc0) && !(pop && (PW'(i) == head));
            hit1[i] = ent_valid[i] && (ent_pc[i] == pc1) && !(pop && (PW'(i) == head));
        end
    end

    assign alloc0    = eff0 & ~(|hit0);
    assign alloc1    = eff1 & ~(|hit1);
    assign tail_plus = tail + PW'(alloc0);

    always_ff @(posedge clock) begin
        if (reset) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ent_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (eff0 && hit0[i]) ent_tgt[i] <= tgt0;
                if (eff1 && hit1[i]) ent_tgt[i] <= tgt1;
            end
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            if (alloc0) begin
                ent_valid[tail] <= 1'b1;
                ent_pc[tail]    <= pc0;
                ent_tgt[tail]   <= tgt0;
            end
            if (alloc1) begin
                ent_valid[tail_plus] <= 1'b1;
                ent_pc[tail_plus]    <= pc1;
                ent_tgt[tail_plus]   <= tgt1;
            end
            tail  <= tail_plus + PW'(alloc1);
            count <= count + CW'(alloc0) + CW'(alloc1) - CW'(pop);
        end
    end

    assign wr_en   = pop;
    assign wr_data = pop ? ent_tgt[head] : '0;
    assign wr_idx  = pop ? ent_pc[head][IDX_W+1:2] : '0;
    assign wr_tag  = pop ? ent_pc[head][TAG_W+IDX_W+1:IDX_W+2] : '0;

`ifdef BTB_UPD_STATS_EN
    logic [1:0]  merges_now;
    logic [32:0] merge_sum;

    assign merges_now = 2'(eff0 & (|hit0)) + 2'(eff1 & (|hit1)) + 2'(same_pc);
    assign merge_sum  = {1'b0, stat_merges} + 33'(merges_now);

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_writes      <= '0;
            stat_merges      <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (pop && (stat_writes != '1))
                stat_writes <= stat_writes + 32'd1;
            stat_merges <= merge_sum[32] ? '1 : merge_sum[31:0];
            if (!rt_ready && (stat_full_cycles != '1))
                stat_full_cycles <= stat_full_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_btb_update_queue.sv
// tb/tb_btb_update_queue.sv - directed table plus randomized run against a queue model
module tb_btb_update_queue;
    localparam int DEPTH = 4;
    localparam int IDX_W = 5;
    localparam int TAG_W = 10;
    localparam int PC_W  = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [1:0]        rt_valid, rt_taken;
    logic [2*PC_W-1:0] rt_pc, rt_target;
    logic              rt_ready, wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [TAG_W-1:0]  wr_tag;
    logic [PC_W-1:0]   wr_data;
    logic [2:0]        count;

    btb_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W), .TAG_W(TAG_W), .PC_W(PC_W)) dut (
        .clock(clock), .reset(reset),
        .rt_valid(rt_valid), .rt_taken(rt_taken), .rt_pc(rt_pc), .rt_target(rt_target),
        .rt_ready(rt_ready), .wr_en(wr_en), .wr_idx(wr_idx), .wr_tag(wr_tag),
        .wr_data(wr_data), .count(count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic [1:0]  v, tk;
        logic [31:0] p0, p1, t0, t1;
        logic        en;
        logic [31:0] data, pc;
        int          cnt;
        logic        rdy;
    } vec_t;
    vec_t tbl[16];

    function automatic vec_t mk(logic [1:0] v, logic [1:0] tk, logic [31:0] p0, logic [31:0] t0,
                                logic [31:0] p1, logic [31:0] t1, logic en, logic [31:0] data,
                                logic [31:0] pc, int cnt, logic rdy);
        vec_t r;
        r.v = v; r.tk = tk; r.p0 = p0; r.p1 = p1; r.t0 = t0; r.t1 = t1;
        r.en = en; r.data = data; r.pc = pc; r.cnt = cnt; r.rdy = rdy;
        return r;
    endfunction

    function automatic logic [31:0] idx_of(logic [31:0] pc);
        return (pc >> 2) & 32'h1f;
    endfunction

    function automatic logic [31:0] tag_of(logic [31:0] pc);
        return (pc >> (IDX_W + 2)) & 32'h3ff;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [1:0] v, logic [1:0] tk, logic [31:0] p0, logic [31:0] t0,
                         logic [31:0] p1, logic [31:0] t1);
        rt_valid  = v;
        rt_taken  = tk;
        rt_pc     = {p1, p0};
        rt_target = {t1, t0};
    endtask

    // Queue model: pop the head, then each taken lane overwrites a waiting match or appends.
    task automatic step_model(logic [1:0] v, logic [1:0] tk, logic [31:0] p0, logic [31:0] t0,
                              logic [31:0] p1, logic [31:0] t1);
        bit ready;
        logic [31:0] lp [2];
        logic [31:0] lt [2];
        ready = (DEPTH - mq.size()) >= 2;
        lp[0] = p0; lp[1] = p1; lt[0] = t0; lt[1] = t1;
        if (mq.size() != 0) void'(mq.pop_front());
        for (int l = 0; l < 2; l++) begin
            if (ready && v[l] && tk[l]) begin
                bit found = 0;
                for (int j = 0; j < mq.size(); j++)
                    if (mq[j].pc == lp[l]) begin
                        mq[j].tgt = lt[l];
                        found = 1;
                    end
                if (!found) mq.push_back('{pc: lp[l], tgt: lt[l]});
            end
        end
    endtask

    task automatic check_model(string name);
        logic [31:0] hp, ht;
        hp = (mq.size() != 0) ? mq[0].pc : 32'h0;
        ht = (mq.size() != 0) ? mq[0].tgt : 32'h0;
        chk({name, ".count"},   32'(count),   32'(mq.size()));
        chk({name, ".wr_en"},   32'(wr_en),   32'(mq.size() != 0));
        chk({name, ".wr_data"}, wr_data,      ht);
        chk({name, ".wr_idx"},  32'(wr_idx),  idx_of(hp));
        chk({name, ".wr_tag"},  32'(wr_tag),  tag_of(hp));
        chk({name, ".rt_ready"}, 32'(rt_ready), 32'((DEPTH - mq.size()) >= 2));
        chk({name, ".no_overflow"}, 32'(count <= 3'(DEPTH)), 32'd1);
    endtask

    initial begin
        logic [1:0]  v, tk;
        logic [31:0] p0, p1, t0, t1;
        int waited;

        tbl[0]  = mk(2'b01, 2'b01, 32'h1040, 32'h2000, 32'h0,    32'h0,   1, 32'h2000, 32'h1040, 1, 1);
        tbl[1]  = mk(2'b00, 2'b00, 32'h0,    32'h0,    32'h0,    32'h0,   0, 32'h0,    32'h0,    0, 1);
        tbl[2]  = mk(2'b11, 2'b00, 32'h500,  32'h55,   32'h600,  32'h66,  0, 32'h0,    32'h0,    0, 1);
        tbl[3]  = mk(2'b11, 2'b11, 32'h1000, 32'hA1,   32'h1004, 32'hB1,  1, 32'hA1,   32'h1000, 2, 1);
        tbl[4]  = mk(2'b11, 2'b11, 32'h1008, 32'hC1,   32'h100C, 32'hD1,  1, 32'hB1,   32'h1004, 3, 0);
        tbl[5]  = mk(2'b11, 2'b11, 32'h1010, 32'hE1,   32'h1014, 32'hF1,  1, 32'hC1,   32'h1008, 2, 1);
        tbl[6]  = mk(2'b00, 2'b00, 32'h0,    32'h0,    32'h0,    32'h0,   1, 32'hD1,   32'h100C, 1, 1);
        tbl[7]  = mk(2'b00, 2'b00, 32'h0,    32'h0,    32'h0,    32'h0,   0, 32'h0,    32'h0,    0, 1);
        tbl[8]  = mk(2'b11, 2'b11, 32'h140,  32'h111,  32'h100,  32'h222, 1, 32'h111,  32'h140,  2, 1);
        tbl[9]  = mk(2'b01, 2'b01, 32'h100,  32'h900,  32'h0,    32'h0,   1, 32'h900,  32'h100,  1, 1);
        tbl[10] = mk(2'b00, 2'b00, 32'h0,    32'h0,    32'h0,    32'h0,   0, 32'h0,    32'h0,    0, 1);
        tbl[11] = mk(2'b11, 2'b11, 32'h200,  32'h300,  32'h200,  32'h400, 1, 32'h400,  32'h200,  1, 1);
        tbl[12] = mk(2'b00, 2'b00, 32'h0,    32'h0,    32'h0,    32'h0,   0, 32'h0,    32'h0,    0, 1);
        tbl[13] = mk(2'b01, 2'b01, 32'h300,  32'h1,    32'h0,    32'h0,   1, 32'h1,    32'h300,  1, 1);
        tbl[14] = mk(2'b01, 2'b01, 32'h300,  32'h2,    32'h0,    32'h0,   1, 32'h2,    32'h300,  1, 1);
        tbl[15] = mk(2'b00, 2'b00, 32'h0,    32'h0,    32'h0,    32'h0,   0, 32'h0,    32'h0,    0, 1);

        reset = 1'b1;
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("reset.count", 32'(count), 0);
        chk("reset.wr_en", 32'(wr_en), 0);
        chk("reset.rt_ready", 32'(rt_ready), 1);
        chk("reset.wr_data", wr_data, 0);
        chk("reset.wr_idx", 32'(wr_idx), 0);
        chk("reset.wr_tag", 32'(wr_tag), 0);

        for (int r = 0; r < 16; r++) begin
            string n;
            n = $sformatf("row%0d", r);
            drive(tbl[r].v, tbl[r].tk, tbl[r].p0, tbl[r].t0, tbl[r].p1, tbl[r].t1);
            @(posedge clock);
            step_model(tbl[r].v, tbl[r].tk, tbl[r].p0, tbl[r].t0, tbl[r].p1, tbl[r].t1);
            @(negedge clock);
            chk({n, ".wr_en"},    32'(wr_en),    32'(tbl[r].en));
            chk({n, ".wr_data"},  wr_data,       tbl[r].data);
            chk({n, ".wr_idx"},   32'(wr_idx),   idx_of(tbl[r].pc));
            chk({n, ".wr_tag"},   32'(wr_tag),   tag_of(tbl[r].pc));
            chk({n, ".count"},    32'(count),    32'(tbl[r].cnt));
            chk({n, ".rt_ready"}, 32'(rt_ready), 32'(tbl[r].rdy));
        end

        for (int n = 0; n < 600; n++) begin
            check_model("rand");
            v  = 2'($urandom);
            tk = 2'($urandom_range(0, 3) != 0 ? $urandom_range(1, 3) : 0);
            p0 = 32'h100 + 32'($urandom_range(0, 5)) * 4;
            p1 = ($urandom_range(0, 3) == 0) ? p0 : 32'h100 + 32'($urandom_range(0, 5)) * 4;
            t0 = $urandom;
            t1 = $urandom;
            drive(v, tk, p0, t0, p1, t1);
            @(posedge clock);
            step_model(v, tk, p0, t0, p1, t1);
            @(negedge clock);
        end
        check_model("rand_end");

        drive(2'b00, 2'b00, 0, 0, 0, 0);
        waited = 0;
        while (mq.size() != 0 && waited < 10) begin
            @(posedge clock);
            step_model(2'b00, 2'b00, 0, 0, 0, 0);
            @(negedge clock);
            waited++;
        end
        chk("drain.count", 32'(count), 0);

        drive(2'b11, 2'b11, 32'h700, 32'h71, 32'h704, 32'h72);
        @(posedge clock);
        @(negedge clock);
        drive(2'b11, 2'b11, 32'h708, 32'h73, 32'h70C, 32'h74);
        @(posedge clock);
        @(negedge clock);
        chk("midrst.pre_count", 32'(count), 3);
        drive(2'b00, 2'b00, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        mq.delete();
        chk("midrst.wr_en", 32'(wr_en), 0);
        chk("midrst.count", 32'(count), 0);
        chk("midrst.rt_ready", 32'(rt_ready), 1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("midrst.no_stale", 32'(wr_en), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
